// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared types and widths for the line memory responder.
package mem_pkg;

  localparam int LINE_B          = 64;
  localparam int MEM_DEPTH_LINES = 1024;
  localparam int OFFSET_W        = $clog2(LINE_B);
  localparam int INDEX_W         = $clog2(MEM_DEPTH_LINES);

  typedef logic [LINE_B*8-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND,
    DRAIN
  } state_t;

endpackage

// File: rtl/line_mem_responder_line_store.sv
// rtl/line_mem_responder_line_store.sv - single-port line array with a registered one-cycle read.
module line_store #(
  parameter int W     = 512,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_in,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately never reset; contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency line-granular memory responder below the LLC.
// Optional range checking on upper address bits: LINE_MEM_RESPONDER_RANGE_CHECK_EN.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int B           = LINE_B,
  parameter int ADDR_BITS   = 64,
  parameter int DEPTH_LINES = MEM_DEPTH_LINES,
  parameter int LATENCY     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic                 req_we_in,
  input  logic [ADDR_BITS-1:0] req_addr_in,
  input  logic [B*8-1:0]       req_line_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic [ADDR_BITS-1:0] rsp_addr_out,
  output logic [B*8-1:0]       rsp_line_out
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
  ,
  output logic                 err_out
`endif
);

  localparam int OFF_BITS = $clog2(B);
  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int CNT_BITS = $clog2(LATENCY + 1);
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'(B - 1);

  state_t                state;
  logic [CNT_BITS-1:0]   cnt;
  logic                  lat_we;
  logic [ADDR_BITS-1:0]  lat_addr;
  logic [B*8-1:0]        lat_line;
  logic                  range_err;
  logic [IDX_BITS-1:0]   store_idx;
  logic                  store_we;
  logic [B*8-1:0]        store_rdata;

`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
  logic req_upper_nz;
  assign req_upper_nz = |req_addr_in[ADDR_BITS-1:OFF_BITS+IDX_BITS];
`else
  assign range_err = 1'b0;
`endif

  // In IDLE the store reads the incoming index so the data is ready even when LATENCY is 1.
  assign store_idx = (state == IDLE) ? req_addr_in[OFF_BITS +: IDX_BITS]
                                     : lat_addr[OFF_BITS +: IDX_BITS];
  assign store_we  = (state == WAIT) && (cnt == '0) && lat_we && !range_err;

  line_store #(
    .W     (B*8),
    .DEPTH (DEPTH_LINES)
  ) u_store (
    .clk_in (clk_in),
    .we     (store_we),
    .idx    (store_idx),
    .wdata  (lat_line),
    .rdata  (store_rdata)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready_out <= 1'b0;
      rsp_valid_out <= 1'b0;
      rsp_addr_out  <= '0;
      rsp_line_out  <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_line      <= '0;
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
      range_err     <= 1'b0;
      err_out       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_out) begin
            lat_we        <= req_we_in;
            lat_addr      <= req_addr_in & ~OFF_MASK;
            lat_line      <= req_line_in;
            cnt           <= CNT_BITS'(LATENCY - 1);
            req_ready_out <= 1'b0;
            state         <= WAIT;
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
            range_err     <= req_upper_nz;
`endif
          end else begin
            req_ready_out <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (lat_we) begin
              state <= DRAIN;
            end else begin
              rsp_valid_out <= 1'b1;
              rsp_addr_out  <= lat_addr;
              rsp_line_out  <= range_err ? '0 : store_rdata;
              state         <= RESPOND;
            end
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
            err_out <= range_err;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            state         <= DRAIN;
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
            err_out       <= 1'b0;
`endif
          end
        end
        DRAIN: begin
          req_ready_out <= 1'b1;
          state         <= IDLE;
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
          err_out       <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - scoreboard bench for line_mem_responder with a reference memory model.
module tb_line_mem_responder;

  localparam int B  = 64;
  localparam int AB = 64;
  localparam int DL = 1024;
  localparam int L  = 8;
  localparam int LW = B*8;

  typedef logic [LW-1:0] line_v;
  typedef struct {
    logic [AB-1:0] addr;
    line_v         line;
    int unsigned   cyc;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic          req_we_in;
  logic [AB-1:0] req_addr_in;
  line_v         req_line_in;
  logic          rsp_valid_out;
  logic          rsp_ready_in;
  logic [AB-1:0] rsp_addr_out;
  line_v         rsp_line_out;
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
  logic          err_out;
`endif

  line_mem_responder #(
    .B           (B),
    .ADDR_BITS   (AB),
    .DEPTH_LINES (DL),
    .LATENCY     (L)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_we_in     (req_we_in),
    .req_addr_in   (req_addr_in),
    .req_line_in   (req_line_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_addr_out  (rsp_addr_out),
    .rsp_line_out  (rsp_line_out)
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
    ,
    .err_out       (err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb[$];
  line_v mem_model [DL];
  bit    known [DL];
  bit    rand_ready = 1'b1;

  task automatic chk(input string name, input line_v act, input line_v exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic line_v fill(input logic [7:0] b);
    line_v r;
    for (int i = 0; i < B; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  function automatic line_v rand_line();
    line_v r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int line_idx(input logic [AB-1:0] a);
    return int'((a / B) % DL);
  endfunction

  function automatic bit upper_nz(input logic [AB-1:0] a);
    return (a / (B * DL)) != 0;
  endfunction

  function automatic line_v exp_read(input logic [AB-1:0] a);
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
    if (upper_nz(a)) return '0;
`endif
    return mem_model[line_idx(a)];
  endfunction

  function automatic void model_write(input logic [AB-1:0] a, input line_v d);
`ifdef LINE_MEM_RESPONDER_RANGE_CHECK_EN
    if (upper_nz(a)) return;
`endif
    mem_model[line_idx(a)] = d;
    known[line_idx(a)] = 1'b1;
  endfunction

  task automatic issue(input bit we, input logic [AB-1:0] a, input line_v d, input bit commit);
    int n = 0;
    exp_t e;
    @(negedge clk_in);
    req_we_in    = we;
    req_addr_in  = a;
    req_line_in  = d;
    req_valid_in = 1'b1;
    while (!req_ready_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 1'b0, 1'b1);
      req_valid_in = 1'b0;
      return;
    end
    if (we) begin
      if (commit) model_write(a, d);
    end else begin
      e.addr = a - (a % B);
      e.line = exp_read(a);
      e.cyc  = cyc + 1 + L;
      sb.push_back(e);
    end
    @(negedge clk_in);
    req_valid_in = 1'b0;
    req_line_in  = rand_line();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid_out || !req_ready_out) && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  // Scoreboard monitor: pops on each new response, then checks it holds stable.
  initial begin
    bit   in_rsp = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (rst_in) begin
        in_rsp = 1'b0;
      end else if (rsp_valid_out) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1'b1, 1'b0);
            e.addr = rsp_addr_out;
            e.line = rsp_line_out;
          end else begin
            e = sb.pop_front();
            chk("rsp_addr", rsp_addr_out, e.addr);
            chk("rsp_line", rsp_line_out, e.line);
            chk("rsp_latency_cycle", cyc, e.cyc);
          end
          in_rsp = 1'b1;
        end else begin
          chk("rsp_addr_stable", rsp_addr_out, e.addr);
          chk("rsp_line_stable", rsp_line_out, e.line);
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (rand_ready) rsp_ready_in = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [AB-1:0] a;
    line_v         d;
    int            acc[$];
    int            n;

    for (int i = 0; i < DL; i++) begin
      mem_model[i] = '0;
      known[i]     = 1'b0;
    end
    rst_in       = 1'b1;
    req_valid_in = 1'b0;
    req_we_in    = 1'b0;
    req_addr_in  = '0;
    req_line_in  = '0;
    rsp_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_req_ready", req_ready_out, 1'b0);
    chk("reset_rsp_valid", rsp_valid_out, 1'b0);
    chk("reset_rsp_addr", rsp_addr_out, '0);
    chk("reset_rsp_line", rsp_line_out, '0);
    rst_in = 1'b0;

    issue(1'b1, 64'h1000, fill(8'hA5), 1'b1);
    issue(1'b0, 64'h1000, rand_line(), 1'b1);
    issue(1'b0, 64'h1038, rand_line(), 1'b1);
    wait_idle();

    // Held response: five stalled cycles, then handshake and the DRAIN dead cycle.
    rand_ready   = 1'b0;
    rsp_ready_in = 1'b0;
    issue(1'b0, 64'h1000, rand_line(), 1'b1);
    n = 0;
    while (!rsp_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("stall_rsp_seen", rsp_valid_out, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", rsp_valid_out, 1'b1);
      chk("stall_req_ready", req_ready_out, 1'b0);
      @(negedge clk_in);
    end
    rsp_ready_in = 1'b1;
    @(negedge clk_in);
    rsp_ready_in = 1'b0;
    chk("post_hs_rsp_valid", rsp_valid_out, 1'b0);
    chk("post_hs_drain_ready", req_ready_out, 1'b0);
    @(negedge clk_in);
    chk("post_drain_ready", req_ready_out, 1'b1);
    rand_ready = 1'b1;
    wait_idle();

    // Back-to-back writes with valid held high.
    d = rand_line();
    @(negedge clk_in);
    req_we_in    = 1'b1;
    req_addr_in  = 64'h3000;
    req_line_in  = d;
    req_valid_in = 1'b1;
    for (int i = 0; i < 3*(L+2); i++) begin
      if (req_ready_out) acc.push_back(int'(cyc) + 1);
      @(negedge clk_in);
    end
    req_valid_in = 1'b0;
    model_write(64'h3000, d);
    chk("b2b_accept_count", acc.size(), 3);
    for (int i = 1; i < acc.size(); i++) chk("b2b_accept_spacing", acc[i] - acc[i-1], L + 2);
    wait_idle();
    issue(1'b0, 64'h3000, rand_line(), 1'b1);
    wait_idle();

    // Reset during a pending write abandons it.
    issue(1'b1, 64'h2000, fill(8'h3C), 1'b1);
    issue(1'b0, 64'h1000, rand_line(), 1'b1);
    wait_idle();
    issue(1'b1, 64'h2000, fill(8'hFF), 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("midreset_req_ready", req_ready_out, 1'b0);
    chk("midreset_rsp_valid", rsp_valid_out, 1'b0);
    chk("midreset_rsp_addr", rsp_addr_out, '0);
    chk("midreset_rsp_line", rsp_line_out, '0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    issue(1'b0, 64'h2000, rand_line(), 1'b1);
    wait_idle();

    // Upper address bits: alias onto line 0, or flagged when range checking is built in.
    issue(1'b1, 64'h0, rand_line(), 1'b1);
    issue(1'b0, 64'h10000, rand_line(), 1'b1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      int idx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1016, 1023));
      a = AB'(idx) * B + AB'($urandom_range(0, B - 1)) + AB'($urandom_range(0, 1)) * (B * DL);
      if ($urandom_range(0, 1) != 0 && known[idx]) issue(1'b0, a, rand_line(), 1'b1);
      else issue(1'b1, a, rand_line(), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
    wait_idle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
